// File: rtl/example_mac_lanes_pkg.sv
// example_mac_lanes_pkg: constants and helpers shared by the MAC lane slice.
//   DEF_*     default widths/depths for the top and lane modules
//   prod_w    full-precision product width of an A_W x B_W signed multiply
//   sat_max / sat_min  largest / smallest two's-complement value of a width,
//             used for clamping when EXAMPLE_MAC_SAT_EN is defined
package example_mac_lanes_pkg;

  localparam int DEF_A_W        = 14;
  localparam int DEF_B_W        = 6;
  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_MUL_STAGES = 2;
  localparam int DEF_ACC_W      = 24;
  localparam int DEF_CNT_W      = 8;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/example_mac_lanes_if.sv
// example_mac_lanes_if: operand stream in, per-lane result stream out.
//   s_valid/s_ready/s_last  input beat handshake and frame end marker
//   s_a, s_b                packed signed operands, lane i at [i*W +: W]
//   m_valid/m_ready         result handshake
//   m_data                  packed signed lane sums, lane i at [i*ACC_W +: ACC_W]
//   m_beats                 beats in the frame (saturating)
//   m_ovf                   per-lane sticky overflow for the frame
// master = stream producer / result consumer, slave = the MAC block.
interface example_mac_lanes_if #(
  parameter int NUM_LANES = 4,
  parameter int A_W       = 14,
  parameter int B_W       = 6,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 8
);
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_last;
  logic [NUM_LANES*A_W-1:0]   s_a;
  logic [NUM_LANES*B_W-1:0]   s_b;
  logic                       m_valid;
  logic                       m_ready;
  logic [NUM_LANES*ACC_W-1:0] m_data;
  logic [CNT_W-1:0]           m_beats;
  logic [NUM_LANES-1:0]       m_ovf;

  modport master (
    output s_valid, s_last, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_data, m_beats, m_ovf
  );

  modport slave (
    input  s_valid, s_last, s_a, s_b, m_ready,
    output s_ready, m_valid, m_data, m_beats, m_ovf
  );
endinterface

// File: rtl/example_mac_lane.sv
// example_mac_lane: one lane of the MAC -- registered signed multiplier
// pipeline followed by the accumulator and sticky overflow flag.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   adv_i          pipeline advance enable (shared by all lanes)
//   a_i, b_i       signed operands of this lane
//   acc_en_i       a valid product leaves the pipeline this cycle
//   last_i         that product closes the frame
//   res_o          acc + product, wrapped or clamped to ACC_W bits
//   ovf_o          sticky overflow including this step
// Build option: EXAMPLE_MAC_SAT_EN clamps on overflow instead of wrapping.
module example_mac_lane
  import example_mac_lanes_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int ACC_W      = DEF_ACC_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    adv_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  input  logic                    acc_en_i,
  input  logic                    last_i,
  output logic signed [ACC_W-1:0] res_o,
  output logic                    ovf_o
);
  localparam int P_W = prod_w(A_W, B_W);

  logic signed [P_W-1:0]   a_x, b_x, prod_d;
  logic signed [P_W-1:0]   prod_q [MUL_STAGES];
  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_q;
  logic signed [ACC_W:0]   sum;
  logic                    of;

  // Operands widened to the product width so the multiply is full precision.
  assign a_x    = {{B_W{a_i[A_W-1]}}, a_i};
  assign b_x    = {{A_W{b_i[B_W-1]}}, b_i};
  assign prod_d = a_x * b_x;

  // Stage 0 .. MUL_STAGES-1: product data only; validity is tracked in the top.
  always_ff @(posedge clk_i) begin
    if (adv_i) begin
      prod_q[0] <= prod_d;
      for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  // Accumulate at one extra bit so overflow shows up as a sign-bit split.
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-P_W){prod_q[MUL_STAGES-1][P_W-1]}}, prod_q[MUL_STAGES-1]};
  assign of  = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef EXAMPLE_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  always_comb begin
    res_o = sum[ACC_W-1:0];
    if (of) res_o = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign res_o = sum[ACC_W-1:0];
`endif

  assign ovf_o = ovf_q | of;

  // Accumulator stage: a closing beat hands its sum to the output and restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_en_i) begin
      if (last_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= res_o;
        ovf_q <= ovf_o;
      end
    end
  end
endmodule

// File: rtl/example_mac_lanes.sv
// example_mac_lanes: NUM_LANES-wide pipelined signed multiply-accumulate.
//   ap_clk    sole clock
//   ap_rst_n  asynchronous active-low reset
//   bus       example_mac_lanes_if.slave: operand stream in, result stream out
// Owns the global advance enable, the valid/last shift register, the beat
// counter and the output register. Per-lane arithmetic is in example_mac_lane.
// Build option: EXAMPLE_MAC_SAT_EN selects clamping instead of wrap on overflow.
module example_mac_lanes
  import example_mac_lanes_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic             ap_clk,
  input logic             ap_rst_n,
  example_mac_lanes_if.slave bus
);
  logic                       adv, ex_vld, ex_last, acc_en, fin;
  logic [MUL_STAGES-1:0]      vld_q, last_q;
  logic [CNT_W-1:0]           cnt_q, cnt_inc;
  logic [NUM_LANES*ACC_W-1:0] data_d, m_data_q;
  logic [NUM_LANES-1:0]       ovf_d, m_ovf_q;
  logic [CNT_W-1:0]           m_beats_q;
  logic                       m_valid_q;

  // Everything moves together; a waiting result freezes the whole datapath.
  assign adv     = !m_valid_q || bus.m_ready;
  assign ex_vld  = vld_q[MUL_STAGES-1];
  assign ex_last = last_q[MUL_STAGES-1];
  assign acc_en  = adv && ex_vld;
  assign fin     = acc_en && ex_last;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign bus.s_ready = adv;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_beats = m_beats_q;
  assign bus.m_ovf   = m_ovf_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic signed [ACC_W-1:0] res;
    logic                    lovf;

    example_mac_lane #(
      .A_W        (A_W),
      .B_W        (B_W),
      .MUL_STAGES (MUL_STAGES),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk_i    (ap_clk),
      .rst_ni   (ap_rst_n),
      .adv_i    (adv),
      .a_i      (bus.s_a[g*A_W +: A_W]),
      .b_i      (bus.s_b[g*B_W +: B_W]),
      .acc_en_i (acc_en),
      .last_i   (ex_last),
      .res_o    (res),
      .ovf_o    (lovf)
    );

    assign data_d[g*ACC_W +: ACC_W] = res;
    assign ovf_d[g]                 = lovf;
  end

  // Stage 0 .. MUL_STAGES-1: valid/last alongside the lane product registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q[0]  <= bus.s_valid;
      last_q[0] <= bus.s_valid && bus.s_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  // Accumulate / output stage: loading a new result takes priority over the
  // handshake clear, so back-to-back results leave no bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_beats_q <= '0;
      m_ovf_q   <= '0;
    end else begin
      if (acc_en) cnt_q <= ex_last ? '0 : cnt_inc;
      if (fin) begin
        m_valid_q <= 1'b1;
        m_data_q  <= data_d;
        m_beats_q <= cnt_inc;
        m_ovf_q   <= ovf_d;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_example_mac_lanes.sv
// tb_example_mac_lanes: directed vectors for example_mac_lanes. Two instances
// receive identical stimulus: one with default widths and one with ACC_W=20
// for the overflow case. Lane 0 carries the directed operands; lane i>0
// carries a=100*i, b=i, so its sum is 100*i*i per beat.
module tb_example_mac_lanes;

  logic ap_clk;
  logic ap_rst_n;
  int   n_checks;
  int   n_fail;

  example_mac_lanes_if #(.NUM_LANES(4), .A_W(14), .B_W(6), .ACC_W(24), .CNT_W(8)) bi ();
  example_mac_lanes_if #(.NUM_LANES(4), .A_W(14), .B_W(6), .ACC_W(20), .CNT_W(8)) bo ();

  example_mac_lanes #(.ACC_W(24)) dut   (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bi));
  example_mac_lanes #(.ACC_W(20)) dut20 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bo));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

`ifdef EXAMPLE_MAC_SAT_EN
  localparam logic signed [63:0] OVF_EXP = 64'sd524287;
`else
  localparam logic signed [63:0] OVF_EXP = -64'sd286813;
`endif

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [23:0] lane_d(input int i);
    return bi.m_data[i*24 +: 24];
  endfunction

  function automatic logic signed [19:0] lane_o(input int i);
    return bo.m_data[i*20 +: 20];
  endfunction

  task automatic set_ready(input logic r);
    bi.m_ready = r;
    bo.m_ready = r;
  endtask

  // Presents one beat to both instances; returns at #1 after the accepting edge.
  task automatic send(input int a0, input int b0, input bit last);
    logic [55:0] av;
    logic [23:0] bv;
    int          n;
    bit          rdy;
    for (int i = 0; i < 4; i++) begin
      av[i*14 +: 14] = (i == 0) ? 14'(a0) : 14'(i * 100);
      bv[i*6 +: 6]   = (i == 0) ? 6'(b0)  : 6'(i);
    end
    bi.s_a = av; bi.s_b = bv; bi.s_last = last; bi.s_valid = 1'b1;
    bo.s_a = av; bo.s_b = bv; bo.s_last = last; bo.s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      rdy = bi.s_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check_val("send_timeout", 0, 1);
    bi.s_valid = 1'b0;
    bo.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bi.m_valid !== 1'b1 && n < 100) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (bi.m_valid !== 1'b1) check_val({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ap_rst_n = 1'b0;
    bi.s_valid = 1'b0; bi.s_last = 1'b0; bi.s_a = '0; bi.s_b = '0;
    bo.s_valid = 1'b0; bo.s_last = 1'b0; bo.s_a = '0; bo.s_b = '0;
    set_ready(1'b1);

    // Reset state
    repeat (2) @(posedge ap_clk);
    #1;
    check_val("rst_mvalid", bi.m_valid, 0);
    check_val("rst_data0", lane_d(0), 0);
    check_val("rst_beats", bi.m_beats, 0);
    check_val("rst_ovf", bi.m_ovf, 0);
    check_val("rst_sready", bi.s_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Three-beat frame with latency check
    send(3, 2, 0);
    send(-5, 7, 0);
    send(100, -1, 1);
    check_val("lat_e0", bi.m_valid, 0);
    @(posedge ap_clk); #1;
    check_val("lat_e1", bi.m_valid, 0);
    @(posedge ap_clk); #1;
    check_val("lat_e2", bi.m_valid, 1);
    check_val("f1_lane0", lane_d(0), -129);
    check_val("f1_lane1", lane_d(1), 300);
    check_val("f1_lane3", lane_d(3), 2700);
    check_val("f1_beats", bi.m_beats, 3);
    check_val("f1_ovf", bi.m_ovf, 0);

    // Single-beat frame, most negative operands
    send(-8192, -32, 1);
    wait_valid("f2");
    check_val("f2_lane0", lane_d(0), 262144);
    check_val("f2_lane2", lane_d(2), 400);
    check_val("f2_beats", bi.m_beats, 1);

    // Overflow in the 20-bit instance only
    send(8191, 31, 0);
    send(8191, 31, 0);
    send(8191, 31, 1);
    wait_valid("f3");
    check_val("f3_lane0_24", lane_d(0), 761763);
    check_val("f3_ovf_24", bi.m_ovf, 0);
    check_val("f3_lane0_20", lane_o(0), OVF_EXP);
    check_val("f3_ovf_20", bo.m_ovf, 1);
    check_val("f3_lane1_20", lane_o(1), 300);
    check_val("f3_beats_20", bo.m_beats, 3);

    // Back-to-back single-beat frames with m_ready high: no bubble
    send(2, 3, 1);
    send(4, 5, 1);
    wait_valid("b2b");
    check_val("b2b_x_lane0", lane_d(0), 6);
    @(posedge ap_clk); #1;
    check_val("b2b_y_valid", bi.m_valid, 1);
    check_val("b2b_y_lane0", lane_d(0), 20);

    // Backpressure across several frames
    @(posedge ap_clk); #1;
    set_ready(1'b0);
    fork
      begin
        send(1, 1, 0);
        send(2, 2, 1);
        send(10, -3, 1);
        send(7, 1, 0);
        send(1, 1, 1);
      end
      begin
        wait_valid("bp_a");
        repeat (3) begin @(posedge ap_clk); #1; end
        check_val("bp_sready", bi.s_ready, 0);
        check_val("bp_a_valid", bi.m_valid, 1);
        check_val("bp_a_lane0", lane_d(0), 5);
        check_val("bp_a_lane1", lane_d(1), 200);
        check_val("bp_a_beats", bi.m_beats, 2);
        set_ready(1'b1);
        @(posedge ap_clk); #1;
        check_val("bp_b_valid", bi.m_valid, 1);
        check_val("bp_b_lane0", lane_d(0), -30);
        check_val("bp_b_beats", bi.m_beats, 1);
        @(posedge ap_clk); #1;
        check_val("bp_gap_valid", bi.m_valid, 0);
        wait_valid("bp_c");
        check_val("bp_c_lane0", lane_d(0), 8);
        check_val("bp_c_lane3", lane_d(3), 1800);
        check_val("bp_c_beats", bi.m_beats, 2);
      end
    join

    // Reset mid-frame with a result pending
    @(posedge ap_clk); #1;
    set_ready(1'b0);
    send(9, 9, 1);
    send(50, 2, 0);
    wait_valid("pre_rst");
    check_val("pre_rst_lane0", lane_d(0), 81);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", bi.m_valid, 0);
    check_val("mid_rst_lane0", lane_d(0), 0);
    check_val("mid_rst_lane3", lane_d(3), 0);
    check_val("mid_rst_beats", bi.m_beats, 0);
    check_val("mid_rst_ovf20", bo.m_ovf, 0);
    check_val("mid_rst_sready", bi.s_ready, 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    set_ready(1'b1);
    @(posedge ap_clk); #1;
    send(1, -1, 1);
    wait_valid("post_rst");
    check_val("post_rst_lane0", lane_d(0), -1);
    check_val("post_rst_lane3", lane_d(3), 900);
    check_val("post_rst_beats", bi.m_beats, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
